// File: rtl/noc_vc_input_buffer_pkg.sv
// Shared types for the VC input buffer: flit word layout and write-side packet states.
// Noc_Data_Width / WR_IDLE / WR_PKT come from the shared Noc_parameters defines; fallbacks are provided if absent.
`ifndef Noc_Data_Width
`define Noc_Data_Width 8
`endif
`ifndef WR_IDLE
`define WR_IDLE 1'b0
`endif
`ifndef WR_PKT
`define WR_PKT 1'b1
`endif

package noc_vc_input_buffer_pkg;

  localparam int unsigned NOC_DW = `Noc_Data_Width;

  typedef enum logic {
    WR_IDLE = `WR_IDLE,
    WR_PKT  = `WR_PKT
  } wr_state_e;

  typedef struct packed {
    logic              header;
    logic              tail;
    logic [NOC_DW-1:0] data;
  } flit_t;

  // Packet framing follows the accepted flit's own header/tail bits.
  function automatic wr_state_e wr_next(input wr_state_e cur, input logic hdr, input logic tail);
    wr_state_e nxt;
    nxt = cur;
    if (tail)     nxt = WR_IDLE;
    else if (hdr) nxt = WR_PKT;
    return nxt;
  endfunction

endpackage

// File: rtl/noc_vc_input_buffer_flit_fifo.sv
// noc_flit_fifo: first-word-fall-through flit storage with wrap-around pointers and occupancy count.
// Read data is the word at the read pointer; storage itself is not reset.
module noc_flit_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                         noc_clk,
  input  logic                         noc_rst_n,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  assign wr_ok = wr_en_i && (count_q != DEPTH_C);
  assign rd_ok = rd_en_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge noc_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Virtual-channel input buffer: flit FIFO plus write-side packet tracking and VC credit (vc_ready_o).
// Optional protocol checker enabled by defining NOC_VC_BUF_PROTO_CHECK_EN.
module noc_vc_input_buffer
  import noc_vc_input_buffer_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned MAX_PKT_FLITS = 4
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [NOC_DW-1:0] in_flit_i,
  input  logic              in_is_header_i,
  input  logic              in_is_tail_i,
  output logic              vc_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [NOC_DW-1:0] out_flit_o,
  output logic              out_is_header_o,
  output logic              out_is_tail_o,
  output logic              err_proto_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_PKT_FLITS);

  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  flit_t         wr_flit, rd_flit;
  logic          wr_acc, rd_acc;
  wr_state_e     wr_state_q, wr_state_d;

  assign in_ready_o  = (count != DEPTH_C);
  assign out_valid_o = (count != '0);
  assign wr_acc      = in_valid_i && in_ready_o;
  assign rd_acc      = out_valid_o && out_ready_i;

  assign free_slots  = DEPTH_C - count;
  assign vc_ready_o  = (free_slots >= MAX_C);

  assign wr_flit = '{header: in_is_header_i, tail: in_is_tail_i, data: in_flit_i};

  noc_flit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(flit_t))
  ) u_fifo (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .wr_en_i   (wr_acc),
    .wr_data_i (wr_flit),
    .rd_en_i   (rd_acc),
    .rd_data_o (rd_flit),
    .count_o   (count)
  );

  // Storage is unreset, so gate the head word until something valid is there.
  assign out_flit_o      = out_valid_o ? rd_flit.data   : '0;
  assign out_is_header_o = out_valid_o ? rd_flit.header : 1'b0;
  assign out_is_tail_o   = out_valid_o ? rd_flit.tail   : 1'b0;

  always_comb begin
    wr_state_d = wr_state_q;
    if (wr_acc) wr_state_d = wr_next(wr_state_q, in_is_header_i, in_is_tail_i);
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) wr_state_q <= WR_IDLE;
    else            wr_state_q <= wr_state_d;
  end

`ifdef NOC_VC_BUF_PROTO_CHECK_EN
  logic err_proto_q, err_proto_d;

  always_comb begin
    err_proto_d = err_proto_q;
    if (wr_acc && (((wr_state_q == WR_IDLE) && !in_is_header_i) ||
                   ((wr_state_q == WR_PKT)  &&  in_is_header_i)))
      err_proto_d = 1'b1;
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) err_proto_q <= 1'b0;
    else            err_proto_q <= err_proto_d;
  end

  assign err_proto_o = err_proto_q;
`else
  assign err_proto_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed self-checking bench for noc_vc_input_buffer (DEPTH=8, MAX_PKT_FLITS=4).
module tb_noc_vc_input_buffer;
  import noc_vc_input_buffer_pkg::*;

  logic              noc_clk = 1'b0;
  logic              noc_rst_n;
  logic              in_valid, in_ready, in_hdr, in_tail;
  logic [NOC_DW-1:0] in_flit;
  logic              vc_ready;
  logic              out_valid, out_ready, out_hdr, out_tail;
  logic [NOC_DW-1:0] out_flit;
  logic              err_proto;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_err;
  logic [NOC_DW+1:0] sb_q [$];

  always #5 noc_clk = ~noc_clk;

  noc_vc_input_buffer #(.DEPTH(8), .MAX_PKT_FLITS(4)) dut (
    .noc_clk         (noc_clk),
    .noc_rst_n       (noc_rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_flit_i       (in_flit),
    .in_is_header_i  (in_hdr),
    .in_is_tail_i    (in_tail),
    .vc_ready_o      (vc_ready),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_flit_o      (out_flit),
    .out_is_header_o (out_hdr),
    .out_is_tail_o   (out_tail),
    .err_proto_o     (err_proto)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [NOC_DW-1:0] f, input logic h, input logic t);
    in_valid = v;
    in_flit  = f;
    in_hdr   = h;
    in_tail  = t;
  endtask

  initial begin
`ifdef NOC_VC_BUF_PROTO_CHECK_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif
    noc_rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_vc_ready", vc_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_out_hdr", out_hdr, 0);
    chk("rst_out_tail", out_tail, 0);
    chk("rst_err", err_proto, 0);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;

    // single header+tail flit: no bypass, visible next cycle
    drive(1'b1, 8'hA5, 1'b1, 1'b1);
    #1;
    chk("lat_no_bypass", out_valid, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lat_valid", out_valid, 1);
    chk("lat_flit", out_flit, 32'hA5);
    chk("lat_hdr", out_hdr, 1);
    chk("lat_tail", out_tail, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lat_drained", out_valid, 0);
    chk("lat_zero_flit", out_flit, 0);

    // fill with two 4-flit packets while the output stalls
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h10 + i), (i % 4) == 0, (i % 4) == 3);
      tick();
      if (i == 3) begin
        chk("fill4_vc_ready", vc_ready, 1);
        chk("fill4_in_ready", in_ready, 1);
      end
      if (i == 4) chk("fill5_vc_ready", vc_ready, 0);
      if (i == 6) chk("fill7_in_ready", in_ready, 1);
      if (i == 7) chk("fill8_in_ready", in_ready, 0);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("stall_flit", out_flit, 32'h10);
    chk("stall_hdr", out_hdr, 1);

    // full with simultaneous read and write attempt
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    out_ready = 1'b1;
    chk("full_in_ready", in_ready, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("full_count", 32'(dut.u_fifo.count_o), 7);
    chk("full_in_ready_after", in_ready, 1);
    chk("full_vc_ready_after", vc_ready, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("drain_word", {out_hdr, out_tail, out_flit},
          {(i == 4), (i == 3) || (i == 7), 8'(8'h10 + i)});
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);

    // 20-flit stream with random back-pressure, scoreboard ordering
    begin
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      while ((idx < 20 || sb_q.size() > 0) && cyc < 400) begin
        drive(idx < 20, 8'(8'h40 + idx), (idx % 4) == 0, (idx % 4) == 3);
        out_ready = 1'($urandom_range(0, 1));
        #0;
        if (out_valid && out_ready) begin
          chk("wrap_word", {out_hdr, out_tail, out_flit}, sb_q[0]);
          void'(sb_q.pop_front());
        end
        if (in_valid && in_ready) begin
          sb_q.push_back({in_hdr, in_tail, in_flit});
          idx++;
        end
        tick();
        cyc++;
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      out_ready = 1'b0;
      chk("wrap_all_sent", idx, 20);
      chk("wrap_sb_empty", sb_q.size(), 0);
      chk("wrap_out_empty", out_valid, 0);
    end

    // protocol: header, body, header without tail
    drive(1'b1, 8'h61, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h62, 1'b0, 1'b0);
    tick();
    chk("proto_clean", err_proto, 0);
    drive(1'b1, 8'h63, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("proto_set", err_proto, exp_err);
    tick();
    tick();
    tick();
    chk("proto_sticky", err_proto, exp_err);
    noc_rst_n = 1'b0;
    #1;
    chk("proto_rst_clear", err_proto, 0);
    #2;
    noc_rst_n = 1'b1;
    tick();

    // reset in the middle of a 4-flit packet
    drive(1'b1, 8'h71, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h72, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("mid_valid", out_valid, 1);
    chk("mid_state", 32'(dut.wr_state_q), 32'(WR_PKT));
    noc_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_vc_ready", vc_ready, 1);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_state", 32'(dut.wr_state_q), 32'(WR_IDLE));
    chk("mid_rst_flit", out_flit, 0);
    #2;
    noc_rst_n = 1'b1;
    drive(1'b1, 8'h80, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_flit", out_flit, 32'h80);
    chk("post_rst_err", err_proto, 0);
    out_ready = 1'b1;
    tick();
    chk("post_rst_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_vc_input_buffer.md
NOC_VC_INPUT_BUFFER -- requirements
Module: noc_vc_input_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, flit slots (power of 2, >= MAX_PKT_FLITS).
REQ-002 SHALL have parameter MAX_PKT_FLITS, default 4, longest legal packet in flits.
REQ-003 SHALL have port noc_clk  in  1  clock; reset noc_rst_n, asynchronous, active-low; clock noc_clk.
REQ-004 SHALL have port noc_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, in_flit in `Noc_Data_Width, in_is_header in 1, in_is_tail in 1: upstream flit stream.
REQ-006 SHALL have port VCready  out  1: buffer can accept one complete new packet.
REQ-007 SHALL have ports out_valid out 1, out_ready in 1, out_flit out `Noc_Data_Width, out_is_header out 1, out_is_tail out 1: stream toward router.
REQ-008 SHALL have port err_proto  out  1: sticky protocol-error flag.

Function
REQ-009 SHALL write a flit on the cycle in which in_valid && in_ready; in_ready = !full (combinational from count only).
REQ-010 SHALL read a flit on the cycle in which out_valid && out_ready; out_valid = !empty; first-word-fall-through.
REQ-011 SHALL give one-cycle latency: a flit written in cycle N is presented with out_valid=1 in cycle N+1; no same-cycle bypass when empty.
REQ-012 SHALL keep header/tail bits alongside each flit; outputs are bit-exact copies of the inputs.
REQ-013 SHALL drive out_flit, out_is_header and out_is_tail to 0 while out_valid=0.
REQ-014 SHALL use wrap-around read/write pointers of width $clog2(DEPTH) and an occupancy count of width $clog2(DEPTH+1).
REQ-015 SHALL apply a simultaneous read and write as count unchanged; when full, no write occurs even if a read occurs that cycle.
REQ-016 SHALL run the write-side FSM with states WR_IDLE and WR_PKT: accepted header without tail moves WR_IDLE->WR_PKT; accepted tail moves to WR_IDLE; accepted header+tail stays in WR_IDLE.
REQ-017 SHALL drive VCready = (DEPTH - count) >= MAX_PKT_FLITS, evaluated combinationally from the current count, so that it is valid in the cycle the upstream tail is presented.
REQ-018 SHALL hold out_* stable while out_valid && !out_ready.

Reset
REQ-019 SHALL, on noc_rst_n low, immediately clear pointers and count, set FSM to WR_IDLE and clear err_proto; resulting outputs are in_ready=1, VCready=1, out_valid=0, out_flit=0, out_is_header=0, out_is_tail=0.
REQ-020 SHALL discard all stored flits, including any partial packet, on reset mid-operation; storage contents need no reset.

Configuration
REQ-021 SHALL, with NOC_VC_BUF_PROTO_CHECK_EN defined, set err_proto sticky on an accepted non-header flit in WR_IDLE or an accepted header in WR_PKT; the flit is still stored and the FSM follows the flit's own header/tail bits.
REQ-022 SHALL, without NOC_VC_BUF_PROTO_CHECK_EN, tie err_proto to 0 with no checking logic.

Structure
REQ-023 SHALL take Noc_Data_Width and the WR_IDLE/WR_PKT encodings from the shared Noc_parameters.v include.
REQ-024 SHALL instantiate storage and pointers in one sub-module, noc_flit_fifo (width `Noc_Data_Width+2, depth DEPTH); packet FSM, VCready and checking live in the top.

Verification
REQ-025 SHALL cover fill: DEPTH=8, MAX_PKT_FLITS=4, write 4 flits, out_ready=0 -> VCready=1; 5th flit -> VCready=0; 8th -> in_ready=0.
REQ-026 SHALL cover latency: a single header+tail flit 0xA5 into empty -> out_valid=1 next cycle with out_flit=0xA5, out_is_header=1, out_is_tail=1.
REQ-027 SHALL cover full + simultaneous: count=8, in_valid=1, out_ready=1 -> one flit read, none written, count=7, in_ready=1 next cycle.
REQ-028 SHALL cover wrap: stream 20 flits with random out_ready -> output order and header/tail bits identical to input, pointers wrap without loss.
REQ-029 SHALL cover protocol: header, body, header (no tail) with the macro defined -> err_proto=1 from the cycle after the 2nd header and held until reset; without the macro it stays 0.
REQ-030 SHALL cover reset mid-packet: assert noc_rst_n low after 2 of 4 flits -> out_valid=0, VCready=1, FSM in WR_IDLE immediately.
